// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types, constants and redirect-target helpers for the fetch unit
package ifu_pkg;

  // Widest PC the queue stores; narrower ADDR_W builds zero-extend into it.
  localparam int IFU_PC_W = 32;

  localparam logic [IFU_PC_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [IFU_PC_W-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

  // Jump target: register target or {upper PC bits, 26-bit index, 00}; always word aligned.
  function automatic logic [IFU_PC_W-1:0] jump_target(
    input logic                sel,
    input logic [IFU_PC_W-1:0] jreg,
    input logic [IFU_PC_W-1:0] redir,
    input logic [25:0]         idx
  );
    logic [IFU_PC_W-1:0] t;
    t = sel ? jreg : {redir[IFU_PC_W-1:28], idx, 2'b00};
    t[1:0] = 2'b00;
    return t;
  endfunction

  // Branch target: PC+4 of the branch plus the word offset, wrapping at the PC width.
  function automatic logic [IFU_PC_W-1:0] branch_target(
    input logic [IFU_PC_W-1:0] redir,
    input logic [31:0]         offset
  );
    logic [IFU_PC_W-1:0] t;
    t = redir + (offset << 2);
    t[1:0] = 2'b00;
    return t;
  endfunction

  // Saturating 32-bit accumulate used by the event counters.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - DEPTH-entry synchronous queue of fetch entries with priority flush
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  output fetch_entry_t           data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push into a full queue is allowed alongside it.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next pointers and occupancy; flush empties the queue and overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only looked at while the queue is non-empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !reset_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - decoupled instruction fetch front end; IFU_PERF_CNT_EN adds event counters
module fetch_queue_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instruction,
  output logic [ADDR_W-1:0] InstrPC,
  output logic [ADDR_W-1:0] NextInstruct,
  output logic              InstrValid,
  input  logic              InstrReady,
  input  logic              Branch,
  input  logic [31:0]       InstructOffset,
  input  logic              Jump,
  input  logic              JumpSel,
  input  logic [25:0]       JumpInstruction,
  input  logic [ADDR_W-1:0] JumpRegister,
  input  logic [ADDR_W-1:0] RedirPC
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = PC_STEP[ADDR_W-1:0];

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  inflight;
  logic              fifo_full, fifo_empty;
  fetch_entry_t      push_entry, head_entry;
  logic              redirect, accept, push, pop, drop_rsp;
  logic [IFU_PC_W-1:0] jump_tgt, branch_tgt;
  logic [ADDR_W-1:0] target;

  // Redirect target: jump has priority over branch.
  assign redirect   = Jump | Branch;
  assign jump_tgt   = jump_target(JumpSel, IFU_PC_W'(JumpRegister), IFU_PC_W'(RedirPC),
                                  JumpInstruction);
  assign branch_tgt = branch_target(IFU_PC_W'(RedirPC), InstructOffset);
  assign target     = Jump ? ADDR_W'(jump_tgt) : ADDR_W'(branch_tgt);

  // Credit: queued plus in-flight words never exceed DEPTH, so every response has a slot.
  // The full term is implied by the credit sum and only keeps the request low defensively.
  assign inflight  = outstanding_q + fifo_count;
  assign imem_req  = ~Reset & ~redirect & ~fifo_full & (inflight < DEPTH_C);
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req & imem_ready;

  // Responses belonging to squashed requests are discarded, including one arriving
  // in the redirect cycle itself.
  assign drop_rsp = imem_rvalid & (redirect | (drop_cnt_q != '0));
  assign push     = imem_rvalid & ~drop_rsp;

  assign push_entry.pc    = IFU_PC_W'(resp_pc_q);
  assign push_entry.instr = imem_rdata;

  // Head presentation; a redirect hides the head so decode cannot consume a squashed word.
  assign InstrValid   = ~Reset & ~redirect & ~fifo_empty;
  assign pop          = InstrValid & InstrReady;
  assign Instruction  = fifo_empty ? '0 : head_entry.instr;
  assign InstrPC      = fifo_empty ? '0 : head_entry.pc[ADDR_W-1:0];
  assign NextInstruct = InstrPC + STEP;

  ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .reset_i (Reset),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Fetch address, PC of the oldest live request, and outstanding/drop bookkeeping.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
    drop_cnt_d    = drop_cnt_q;
    if (redirect) begin
      // Everything still in flight after this cycle is stale, whatever drop_cnt held.
      fetch_pc_d = target;
      resp_pc_d  = target;
      drop_cnt_d = outstanding_q - CNT_W'(imem_rvalid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + STEP;
      if (push)   resp_pc_d  = resp_pc_q + STEP;
      if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // Fetch state registers; reset overrides redirect and all other events.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0]      perf_fetched_q, perf_squashed_q, perf_stall_q;
  logic [CNT_W-1:0] squash_inc;

  // Squashed words this cycle: flushed queue entries plus a discarded response.
  assign squash_inc = (redirect ? fifo_count : '0) + CNT_W'(drop_rsp);

  // Saturating event counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      perf_fetched_q  <= '0;
      perf_squashed_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_fetched_q  <= sat_add32(perf_fetched_q, 32'(pop));
      perf_squashed_q <= sat_add32(perf_squashed_q, 32'(squash_inc));
      perf_stall_q    <= sat_add32(perf_stall_q, 32'(InstrReady & ~InstrValid));
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
  assign perf_stall    = perf_stall_q;
`endif

endmodule
